// File: rtl/rcon_if.sv
// rcon_if: control strobes and constant outputs between the key-expansion controller and rcon_seq
interface rcon_if #(
    parameter int WORD_W = 32
);
    logic              start;
    logic [1:0]        mode;
    logic              dir;
    logic              next;
    logic [WORD_W-1:0] rcon_out;
    logic [3:0]        round_out;
    logic              rcon_valid;
    logic              last;
    logic              done;
    logic              err;

    modport master (
        output start, mode, dir, next,
        input  rcon_out, round_out, rcon_valid, last, done, err
    );

    modport slave (
        input  start, mode, dir, next,
        output rcon_out, round_out, rcon_valid, last, done, err
    );
endinterface

// File: rtl/rcon_seq.sv
// rcon_seq: iterative AES round-constant generator, GF(2^8) doubling forward and halving reverse
module rcon_seq #(
    parameter int         WORD_W   = 32,
    parameter int         BYTE_POS = WORD_W / 8 - 1,
    parameter logic [7:0] POLY     = 8'h1B
) (
    input logic   clk,
    input logic   rst_n,
    rcon_if.slave bus
);
    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t     state_q, state_d;
    logic [7:0] rc_q, rc_d, rc_init, rc_dbl, rc_half;
    logic [3:0] round_q, round_d, nrounds_q, nrounds_d, nr_sel;
    logic       dir_q, dir_d, done_q, done_d, err_q, err_d, last;

    always_comb begin
        nr_sel    = bus.mode == 2'b00 ? 4'd10 : bus.mode == 2'b01 ? 4'd8 : 4'd7;
        rc_init   = !bus.dir ? 8'h01 : bus.mode == 2'b00 ? 8'h36 : bus.mode == 2'b01 ? 8'h80 : 8'h40;
        rc_dbl    = {rc_q[6:0], 1'b0} ^ (rc_q[7] ? POLY : 8'h00);
        rc_half   = rc_q[0] ? (((rc_q ^ POLY) >> 1) | 8'h80) : rc_q >> 1;
        last      = state_q == ACTIVE && round_q == (dir_q ? 4'd1 : nrounds_q);
        state_d   = state_q;
        rc_d      = rc_q;
        round_d   = round_q;
        nrounds_d = nrounds_q;
        dir_d     = dir_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        // a reserved-mode start freezes everything, including a concurrent next
        if (bus.start && bus.mode == 2'b11) begin
            err_d = 1'b1;
        end else if (bus.start) begin
            state_d   = ACTIVE;
            nrounds_d = nr_sel;
            dir_d     = bus.dir;
            rc_d      = rc_init;
            round_d   = bus.dir ? nr_sel : 4'd1;
        end else if (state_q == ACTIVE && bus.next) begin
            state_d = last ? IDLE : ACTIVE;
            done_d  = last;
            rc_d    = last ? 8'h00 : dir_q ? rc_half : rc_dbl;
            round_d = last ? 4'd0 : dir_q ? round_q - 4'd1 : round_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rc_q      <= 8'h00;
            round_q   <= 4'd0;
            nrounds_q <= 4'd0;
            dir_q     <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rc_q      <= rc_d;
            round_q   <= round_d;
            nrounds_q <= nrounds_d;
            dir_q     <= dir_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // rc and round are cleared whenever the sequencer leaves ACTIVE, so idle outputs read as zero
    assign bus.rcon_out   = WORD_W'(rc_q) << (8 * BYTE_POS);
    assign bus.round_out  = round_q;
    assign bus.rcon_valid = state_q == ACTIVE;
    assign bus.last       = last;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_rcon_seq.sv
// tb_rcon_seq: table-driven reference model checked every cycle against 32-bit MSB-lane and 64-bit lane-0 instances
module tb_rcon_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    rcon_if #(.WORD_W(32)) b32 ();
    rcon_if #(.WORD_W(64)) b64 ();

    assign b64.start = b32.start;
    assign b64.mode  = b32.mode;
    assign b64.dir   = b32.dir;
    assign b64.next  = b32.next;

    rcon_seq #(.WORD_W(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32.slave));
    rcon_seq #(.WORD_W(64), .BYTE_POS(0)) dut64 (.clk(clk), .rst_n(rst_n), .bus(b64.slave));

    logic [7:0] tbl [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

    bit m_active, m_dir, m_done, m_err;
    int m_round, m_nr;

    function automatic bit m_last();
        return m_active && m_round == (m_dir ? 1 : m_nr);
    endfunction

    function automatic logic [7:0] m_rc();
        return m_active ? tbl[m_round-1] : 8'h00;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0; m_round = 0; m_nr = 0; m_dir = 0; m_done = 0; m_err = 0;
        end else begin
            bit lst;
            lst    = m_last();
            m_done = 0;
            m_err  = 0;
            if (b32.start && b32.mode == 2'd3) m_err = 1;
            else if (b32.start) begin
                m_active = 1;
                m_nr     = b32.mode == 2'd0 ? 10 : b32.mode == 2'd1 ? 8 : 7;
                m_dir    = b32.dir;
                m_round  = b32.dir ? m_nr : 1;
            end else if (m_active && b32.next) begin
                if (lst) begin
                    m_active = 0; m_done = 1; m_round = 0;
                end else m_round += m_dir ? -1 : 1;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("rcon32", {32'h0, b32.rcon_out}, {32'h0, m_rc(), 24'h0});
        chk("rcon64", b64.rcon_out, {56'h0, m_rc()});
        chk("round", {60'h0, b32.round_out}, 64'(m_active ? m_round : 0));
        chk("round64", {60'h0, b64.round_out}, 64'(m_active ? m_round : 0));
        chk("valid", {63'h0, b32.rcon_valid}, {63'h0, m_active});
        chk("last", {63'h0, b32.last}, {63'h0, m_last()});
        chk("done", {62'h0, b32.done, b64.done}, {62'h0, m_done, m_done});
        chk("err", {62'h0, b32.err, b64.err}, {62'h0, m_err, m_err});
    end

    task automatic cyc(input bit s, input bit [1:0] m, input bit d, input bit n);
        b32.start = s; b32.mode = m; b32.dir = d; b32.next = n;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        b32.start = 0; b32.mode = 0; b32.dir = 0; b32.next = 0;
        #12;
        chk("reset_rcon", {32'h0, b32.rcon_out}, 64'h0);
        chk("reset_valid", {63'h0, b32.rcon_valid}, 64'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // AES-128 forward, next held high
        cyc(1, 2'd0, 0, 0);
        chk("fwd128_first", {32'h0, b32.rcon_out}, 64'h01000000);
        for (int i = 0; i < 9; i++) cyc(0, 2'd0, 0, 1);
        chk("fwd128_last_val", {32'h0, b32.rcon_out}, 64'h36000000);
        chk("fwd128_last64", b64.rcon_out, 64'h36);
        chk("fwd128_last", {63'h0, b32.last}, 64'h1);
        cyc(0, 2'd0, 0, 1);
        chk("fwd128_done", {62'h0, b32.done, b32.rcon_valid}, 64'h2);
        // start in the done cycle: AES-256 reverse
        cyc(1, 2'd2, 1, 0);
        chk("b2b_rev256", {32'h0, b32.rcon_out}, 64'h40000000);
        chk("b2b_round", {60'h0, b32.round_out}, 64'd7);
        for (int i = 0; i < 7; i++) cyc(0, 2'd0, 0, 1);
        // AES-192 reverse with random gaps
        cyc(1, 2'd1, 1, 0);
        chk("rev192_first", {32'h0, b32.rcon_out}, 64'h80000000);
        k = 0;
        while (m_active && k < 200) begin
            cyc(0, 2'd0, 0, 1'($urandom_range(0, 1)));
            k++;
        end
        if (m_active) begin
            fails++;
            $display("FAIL rev192_timeout: still active after %0d cycles", k);
        end
        cyc(0, 2'd0, 0, 0);
        // AES-256 forward, restart as AES-128 reverse together with next at round 4
        cyc(1, 2'd2, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 2'd0, 0, 1);
        chk("fwd256_r4", {60'h0, b32.round_out}, 64'd4);
        cyc(1, 2'd0, 1, 1);
        chk("restart_val", {32'h0, b32.rcon_out}, 64'h36000000);
        chk("restart_round", {60'h0, b32.round_out}, 64'd10);
        chk("restart_nodone", {63'h0, b32.done}, 64'h0);
        for (int i = 0; i < 10; i++) cyc(0, 2'd0, 0, 1);
        // async reset mid-sequence at round 5
        cyc(1, 2'd0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 2'd0, 0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_rcon", {32'h0, b32.rcon_out}, 64'h0);
        chk("rst_round", {60'h0, b32.round_out}, 64'h0);
        chk("rst_valid", {63'h0, b32.rcon_valid}, 64'h0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) cyc(0, 2'd0, 0, 1);
        chk("rst_next_ignored", {63'h0, b32.rcon_valid}, 64'h0);
        // reserved mode in IDLE and in ACTIVE at round 3
        cyc(1, 2'd3, 0, 0);
        chk("err_idle", {62'h0, b32.err, b32.rcon_valid}, 64'h2);
        cyc(1, 2'd0, 0, 0);
        cyc(0, 2'd0, 0, 1);
        cyc(0, 2'd0, 0, 1);
        cyc(1, 2'd3, 1, 1);
        chk("err_active", {62'h0, b32.err, b32.rcon_valid}, 64'h3);
        chk("err_hold", {60'h0, b32.round_out}, 64'd3);
        cyc(0, 2'd0, 0, 0);
        chk("err_once", {63'h0, b32.err}, 64'h0);
        // randomized traffic
        for (int i = 0; i < 600; i++)
            cyc(1'($urandom_range(0, 7) == 0), 2'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0));
        cyc(0, 2'd0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
